// File: rtl/demux_pkg.sv
// Shared types for the 1-to-4 stream demux: channel count, select type,
// holding-register state and the one-hot channel decode.
package demux_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot(input sel_t sel);
        logic [NUM_CH-1:0] vec;
        vec      = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/demux_ch_counter.sv
// Wrapping per-channel transfer counter, increments by one when en is high.
// Result visible the cycle after the counted transfer; no flow control.
module demux_ch_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/demux_1_to_4_stream.sv
// 1-to-4 valid/ready demux through a one-entry register: 1-cycle latency, full throughput,
// in_ready follows the addressed sink's ready. DEMUX_CNT_EN adds per-channel transfer counters.
module demux_1_to_4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [1:0]        in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    input  logic [1:0]        cnt_sel,
    output logic [CNT_W-1:0]  cnt_out
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    sel_t             dest_q, dest_d;
    logic             in_xfer;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        dest_d    = dest_q;
        in_ready  = 1'b1;
        out_valid = '0;
        case (state_q)
            EMPTY: begin
                in_ready = 1'b1;
            end
            FULL: begin
                in_ready = out_ready[dest_q];
                // Masked during reset so a discarded word never counts as delivered.
                out_valid = reset ? 4'b0000 : onehot(dest_q);
            end
            default: begin
                in_ready = 1'b1;
            end
        endcase
        in_xfer = in_valid && in_ready;
        if (in_xfer) begin
            state_d = FULL;
            data_d  = in_data;
            dest_d  = in_sel;
        end else if (state_q == FULL && out_ready[dest_q]) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
        end
    end

    assign out_data = data_q;

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_ch [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        demux_ch_counter #(
            .W (CNT_W)
        ) u_cnt (
            .clock (clock),
            .reset (reset),
            .en    (out_valid[g] && out_ready[g]),
            .cnt   (cnt_ch[g])
        );
    end

    assign cnt_out = cnt_ch[cnt_sel];
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_out        = '0;
`endif

endmodule

// File: doc/demux_1_to_4_stream.md
DEMUX_1_TO_4_STREAM -- requirements
Module: demux_1_to_4_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (1..64).
REQ-002 SHALL have parameter CNT_W, default 8, per-channel transfer counter width.
REQ-003 SHALL have port clock, input, 1, single rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset sampled on clock rising edge.
REQ-005 SHALL have port in_data, input, WIDTH, source data word.
REQ-006 SHALL have port in_sel, input, 2, destination channel (0..3), qualified by in_valid.
REQ-007 SHALL have port in_valid, input, 1, source word present.
REQ-008 SHALL have port in_ready, output, 1, block accepts the word this cycle.
REQ-009 SHALL have port out_data, output, WIDTH, shared data bus to all four channels.
REQ-010 SHALL have port out_valid, output, 4, one-hot valid, bit n = channel n.
REQ-011 SHALL have port out_ready, input, 4, per-channel sink ready.
REQ-012 SHALL have port cnt_sel, input, 2, channel whose transfer count appears on cnt_out (macro only).
REQ-013 SHALL have port cnt_out, output, CNT_W, transfer count of channel cnt_sel (macro only).

Function
REQ-014 SHALL transfer on input when in_valid && in_ready; on channel n when out_valid[n] && out_ready[n].
REQ-015 SHALL hold a one-entry output register (data, 2-bit dest) with state machine EMPTY/FULL.
REQ-016 EMPTY: in_ready=1, out_valid=0; input transfer -> capture in_data/in_sel, go FULL.
REQ-017 FULL: out_valid = one-hot(dest), out_data = held data; in_ready = out_ready[dest].
REQ-018 FULL, output transfer with simultaneous input transfer -> reload register with new word, stay FULL (full throughput, 1 word/cycle).
REQ-019 FULL, output transfer without input transfer -> go EMPTY.
REQ-020 FULL, no output transfer -> hold data/dest stable; in_ready=0; in_data/in_sel ignored.
REQ-021 Latency: word accepted in cycle k SHALL appear on out_valid in cycle k+1.
REQ-022 out_valid SHALL never have more than one bit set; out_ready of non-addressed channels SHALL be ignored.
REQ-023 in_ready SHALL depend combinationally only on state, dest and out_ready, never on in_valid.
REQ-024 out_data SHALL retain last held value when EMPTY (no zeroing after reset release).

Reset
REQ-025 reset SHALL force state EMPTY, out_valid=4'b0000, out_data=0, dest=0, all counters 0, in_ready=1 from the next cycle.
REQ-026 reset asserted while FULL SHALL discard the held word with no output transfer that cycle; reset overrides any simultaneous input transfer.

Configuration
REQ-027 Macro DEMUX_CNT_EN defined: four CNT_W-bit counters, counter n increments on each channel-n output transfer, wraps 2^CNT_W-1 -> 0; cnt_out = counter[cnt_sel] combinationally.
REQ-028 Macro undefined: no counters, cnt_sel ignored, cnt_out tied to 0; port list unchanged.

Structure
REQ-029 Package demux_pkg SHALL hold NUM_CH=4, sel type (2-bit), state enum {EMPTY, FULL}, one-hot decode function.
REQ-030 Sub-module demux_ch_counter (one wrapping counter with enable and synchronous reset) SHALL be instantiated four times under DEMUX_CNT_EN.

Verification
REQ-031 Reset then in_data=8'hA5, in_sel=2, in_valid 1 cycle, out_ready=4'b1111 -> next cycle out_valid=4'b0100, out_data=A5, then EMPTY.
REQ-032 Stream 8'h01..8'h04 with in_sel=0,1,2,3 back-to-back, out_ready all 1 -> out_valid 0001,0010,0100,1000 on consecutive cycles, in_ready constant 1.
REQ-033 Word 8'h3C to ch 1, out_ready=4'b1101 for 3 cycles -> out_valid=0010, data 3C stable, in_ready=0; raise out_ready[1] -> transfer, in_ready=1.
REQ-034 FULL with 8'h77 to ch 3, assert reset -> next cycle out_valid=0000, in_ready=1, no ch-3 transfer.
REQ-035 DEMUX_CNT_EN, CNT_W=8: 257 transfers to ch 2 -> cnt_sel=2 gives cnt_out=1; cnt_sel=0 gives 0.
REQ-036 Random in_valid/out_ready, 10k cycles -> scoreboard order/data per channel exact, out_valid one-hot or zero every cycle.
